// File: rtl/lcd_spi_rx_pkg.sv
// Shared types and constants for the LCD SPI receive path.
// Received words are stored as the 17-bit record {dcx, data[15:0]}.
package lcd_spi_rx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int LEN8 = 8;

  // Field offsets of the rx word record
  localparam int RXW_DATA_LSB = 0;
  localparam int RXW_DATA_MSB = 15;
  localparam int RXW_DCX_BIT  = 16;
  localparam int RXW_WIDTH    = 17;

  function automatic logic [RXW_WIDTH-1:0] pack_word(input logic dcx, input logic [15:0] data);
    return {dcx, data};
  endfunction

endpackage

// File: rtl/lcd_spi_rx_if.sv
// Received-word stream: valid/ready handshake, transfer when rx_valid & rx_ready on posedge clk.
// rx_data/rx_dcx are stable while rx_valid is high and the word has not been accepted.
interface lcd_spi_rx_if;
  logic [15:0] rx_data;
  logic        rx_dcx;
  logic        rx_valid;
  logic        rx_ready;

  modport master (output rx_data, output rx_dcx, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_dcx, input rx_valid, output rx_ready);
endinterface

// File: rtl/lcd_rx_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; a pop in the same cycle frees space for a push.
module lcd_rx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Pop is resolved first so a full FIFO can accept a push in the same cycle
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= din;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/lcd_spi_rx.sv
// Rebuilds 8/16-bit LCD SPI words from CSX/DCX/SCK/SDO and queues them with their DCX level.
// Define LCD_SPI_RX_SYNC_EN to add 2-flop synchronizers on the SPI inputs for an asynchronous master.
module lcd_spi_rx
  import lcd_spi_rx_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W16   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode16,
  input  logic          CSX,
  input  logic          DCX,
  input  logic          SCK,
  input  logic          SDO,
  input  logic          clr_err,
  lcd_spi_rx_if.master  rx_if,
  output logic          overrun,
  output logic          frame_err,
  output logic          busy,
  output state_t        dbg_state
);

  logic w_csx, w_dcx, w_sck, w_sdo;

`ifdef LCD_SPI_RX_SYNC_EN
  logic [1:0] r_csx_s, r_dcx_s, r_sck_s, r_sdo_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csx_s <= 2'b11;
      r_dcx_s <= 2'b00;
      r_sck_s <= 2'b00;
      r_sdo_s <= 2'b00;
    end else begin
      r_csx_s <= {r_csx_s[0], CSX};
      r_dcx_s <= {r_dcx_s[0], DCX};
      r_sck_s <= {r_sck_s[0], SCK};
      r_sdo_s <= {r_sdo_s[0], SDO};
    end
  end

  assign w_csx = r_csx_s[1];
  assign w_dcx = r_dcx_s[1];
  assign w_sck = r_sck_s[1];
  assign w_sdo = r_sdo_s[1];
`else
  assign w_csx = CSX;
  assign w_dcx = DCX;
  assign w_sck = SCK;
  assign w_sdo = SDO;
`endif

  state_t      r_state, w_state_next;
  logic [15:0] r_shift, w_shift_next;
  logic [4:0]  r_cnt, w_cnt_next;
  logic [4:0]  r_len, w_len_next;
  logic        r_sck_q;
  logic        r_overrun, r_frame_err;
  logic        w_rise;
  logic        w_push;
  logic        w_frame_set;
  logic [4:0]  w_cnt_inc;
  logic [RXW_WIDTH-1:0] w_word;
  logic [RXW_WIDTH-1:0] w_dout;
  logic        w_full, w_empty;
  logic        w_ovr_set;

  // SDO is taken in the same cycle the rise is seen; the master moves SDO on the next edge
  assign w_rise    = w_sck & ~r_sck_q & ~w_csx;
  assign w_cnt_inc = r_cnt + 5'd1;

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_len_next   = r_len;
    w_push       = 1'b0;
    w_frame_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_shift_next = {15'd0, w_sdo};
          w_cnt_next   = 5'd1;
          w_len_next   = mode16 ? 5'(W16) : 5'(LEN8);
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_csx) begin
          w_frame_set  = 1'b1;
          w_cnt_next   = 5'd0;
          w_state_next = ST_IDLE;
        end else if (w_rise) begin
          w_shift_next = {r_shift[14:0], w_sdo};
          w_cnt_next   = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_push       = 1'b1;
            w_cnt_next   = 5'd0;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Upper bits start at zero on the first bit, so an 8-bit word lands zero-extended
  assign w_word = pack_word(w_dcx, w_shift_next);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_sck_q <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      r_len   <= w_len_next;
      r_sck_q <= w_sck;
    end
  end

  lcd_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RXW_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (w_push),
    .pop   (rx_if.rx_ready),
    .din   (w_word),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // A full FIFO only drops the word if the consumer is not taking the head this cycle
  assign w_ovr_set = w_push & w_full & ~rx_if.rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
      if (w_frame_set)  r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
    end
  end

  assign rx_if.rx_data  = w_dout[RXW_DATA_MSB:RXW_DATA_LSB];
  assign rx_if.rx_dcx   = w_dout[RXW_DCX_BIT];
  assign rx_if.rx_valid = ~w_empty;
  assign overrun        = r_overrun;
  assign frame_err      = r_frame_err;
  assign busy           = (r_state == ST_SHIFT);
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed + randomized bench for lcd_spi_rx; SPI master driven on negedge, SCK toggling every clk.
module tb_lcd_spi_rx;
  import lcd_spi_rx_pkg::*;

  logic   clk = 1'b0;
  logic   reset, mode16, CSX, DCX, SCK, SDO, clr_err;
  logic   overrun, frame_err, busy;
  state_t dbg_state;

  lcd_spi_rx_if rx_if();

  lcd_spi_rx #(.DEPTH(2), .W16(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode16    (mode16),
    .CSX       (CSX),
    .DCX       (DCX),
    .SCK       (SCK),
    .SDO       (SDO),
    .clr_err   (clr_err),
    .rx_if     (rx_if),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [16:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mdl_cnt  = 0;
  logic        exp_ovr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on a negedge with SCK low; leaves on the negedge after SCK falls
  task automatic send_bit(input logic b);
    SCK = 1'b1;
    SDO = b;
    @(negedge clk);
    SCK = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] d, input int len, input logic dcx);
    DCX    = dcx;
    mode16 = (len == 16);
    for (int i = len - 1; i >= 0; i--) send_bit(d[i]);
    if (mdl_cnt < 2) begin
      exp_q.push_back({dcx, d});
      mdl_cnt++;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [16:0] e;
    check({tag, "_valid"}, 32'(rx_if.rx_valid), 32'd1);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: observed word with empty scoreboard, required none", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'({rx_if.rx_dcx, rx_if.rx_data}), 32'(e));
    end
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    mdl_cnt--;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0]  b8;
  logic [15:0] w16;
  logic [16:0] e17;
  int          rlen;

  initial begin
    reset = 1'b1; mode16 = 1'b0; CSX = 1'b1; DCX = 1'b0; SCK = 1'b0; SDO = 1'b0;
    clr_err = 1'b0; rx_if.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data",  32'(rx_if.rx_data), 32'd0);
    check("rst_dcx",   32'(rx_if.rx_dcx), 32'd0);
    check("rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check("rst_ovr",   32'(overrun), 32'd0);
    check("rst_ferr",  32'(frame_err), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);
    CSX = 1'b0;
    @(negedge clk);

    // 8-bit command 0x2A, valid exactly one cycle after the 8th rise
    b8 = 8'h2A; DCX = 1'b0; mode16 = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      send_bit(b8[i]);
      if (i == 7) check("t1_busy_first", 32'(busy), 32'd1);
    end
    check("t1_valid_before", 32'(rx_if.rx_valid), 32'd0);
    send_bit(b8[0]);
    check("t1_valid_after", 32'(rx_if.rx_valid), 32'd1);
    check("t1_busy_done", 32'(busy), 32'd0);
    exp_q.push_back({1'b0, 16'h002A});
    mdl_cnt++;
    pop_check("t1_word");
    check("t1_empty", 32'(rx_if.rx_valid), 32'd0);

    // 16-bit pixel 0xF81F, busy from the 1st rise through the 16th
    w16 = 16'hF81F; DCX = 1'b1; mode16 = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      check("t2_busy", 32'(busy), (i < 15) ? 32'd1 : 32'd0);
      send_bit(w16[i]);
    end
    check("t2_busy_done", 32'(busy), 32'd0);
    exp_q.push_back({1'b1, 16'hF81F});
    mdl_cnt++;
    pop_check("t2_word");

    // Overrun: third word dropped while consumer stalls
    send_word(16'h0011, 8, 1'b0);
    send_word(16'h0022, 8, 1'b0);
    send_word(16'h0033, 8, 1'b0);
    check("t3_ovr", 32'(overrun), 32'(exp_ovr));
    pop_check("t3_pop1");
    pop_check("t3_pop2");
    check("t3_empty", 32'(rx_if.rx_valid), 32'd0);
    pulse_clr();
    exp_ovr = 1'b0;
    check("t3_ovr_clr", 32'(overrun), 32'(exp_ovr));

    // Frame abort after 5 bits, then a clean byte
    b8 = 8'hA5; DCX = 1'b0; mode16 = 1'b0;
    for (int i = 7; i >= 3; i--) send_bit(b8[i]);
    CSX = 1'b1;
    @(negedge clk);
    check("t4_ferr",  32'(frame_err), 32'd1);
    check("t4_busy",  32'(busy), 32'd0);
    check("t4_valid", 32'(rx_if.rx_valid), 32'd0);
    check("t4_state", 32'(dbg_state), 32'(ST_IDLE));
    CSX = 1'b0;
    @(negedge clk);
    send_word(16'h003C, 8, 1'b1);
    pop_check("t4_word");
    check("t4_ferr_sticky", 32'(frame_err), 32'd1);
    pulse_clr();
    check("t4_ferr_clr", 32'(frame_err), 32'd0);

    // Full FIFO with a pop on the completing cycle: no overrun, order kept
    send_word(16'h0081, 8, 1'b0);
    send_word(16'h0042, 8, 1'b1);
    b8 = 8'hC3; DCX = 1'b0; mode16 = 1'b0;
    for (int i = 7; i >= 1; i--) send_bit(b8[i]);
    e17 = exp_q.pop_front();
    check("t5_head", 32'({rx_if.rx_dcx, rx_if.rx_data}), 32'(e17));
    rx_if.rx_ready = 1'b1;
    SCK = 1'b1;
    SDO = b8[0];
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    SCK = 1'b0;
    @(negedge clk);
    exp_q.push_back({1'b0, 16'h00C3});
    check("t5_ovr", 32'(overrun), 32'd0);
    pop_check("t5_pop1");
    pop_check("t5_pop2");
    check("t5_empty", 32'(rx_if.rx_valid), 32'd0);

    // Async reset in the middle of a word
    b8 = 8'h96;
    for (int i = 7; i >= 4; i--) send_bit(b8[i]);
    check("t6_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_busy",  32'(busy), 32'd0);
    check("t6_valid", 32'(rx_if.rx_valid), 32'd0);
    check("t6_data",  32'(rx_if.rx_data), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    mdl_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_word(16'h005A, 8, 1'b0);
    pop_check("t6_word");
    check("t6_ferr", 32'(frame_err), 32'd0);

    // Randomized words, each consumed right away
    repeat (6) begin
      rlen = ($urandom_range(0, 1) == 1) ? 16 : 8;
      w16  = 16'($urandom_range(0, 16'hFFFF));
      if (rlen == 8) w16[15:8] = 8'h00;
      send_word(w16, rlen, 1'($urandom_range(0, 1)));
      pop_check("rnd_word");
    end
    check("rnd_empty", 32'(rx_if.rx_valid), 32'd0);
    check("rnd_ovr", 32'(overrun), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
